// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Imported by the responder top and its storage array.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_2000;
   localparam int          STRB_WIDTH        = 4;

endpackage

// File: rtl/dmem_array.sv
// Byte-strobed data RAM with a synchronous write port.
// Its read-data register samples the addressed word on every clock edge.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
   input  logic                  clk,
   input  logic                  we,
   input  logic [STRB_WIDTH-1:0] wstrb,
   input  logic [IDX_W-1:0]      idx,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [DEPTH];

   // NOTE: storage has no reset; a clear would force a flop array instead of RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      rdata <= mem[idx];
   end

endmodule

// File: rtl/dmem_responder.sv
// Target side of the data-memory interface: word RAM at BASE_ADDR with wait states.
// Handshake is valid/ready on both the request and response channels.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    DEPTH       = 64,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
   parameter int                    WAIT_STATES = 2
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [STRB_WIDTH-1:0] req_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

   state_t                  state, next_state;
   logic [CNT_W-1:0]        cnt;
   logic                    write_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [STRB_WIDTH-1:0]   wstrb_q;
   logic                    load_ok_q;

   logic                    accept, enter_resp, ram_we, dec_err;
   logic                    cur_write;
   logic [ADDR_WIDTH-1:0]   cur_addr, offset;
   logic [DATA_WIDTH-1:0]   cur_wdata;
   logic [STRB_WIDTH-1:0]   cur_wstrb;
   logic [ADDR_WIDTH-3:0]   word;
   logic [31:0]             ram_rdata;

   // In IDLE the live request is decoded so a zero-wait access can hit the RAM on its accept edge.
   assign cur_write = (state == IDLE) ? req_write : write_q;
   assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
   assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
   assign cur_wstrb = (state == IDLE) ? req_wstrb : wstrb_q;

   assign offset  = cur_addr - BASE_ADDR;
   assign word    = offset[ADDR_WIDTH-1:2];
   assign dec_err = (offset[1:0] != 2'b00) || (word >= (ADDR_WIDTH-2)'(DEPTH));

   assign accept     = (state == IDLE) && req_valid;
   assign enter_resp = (state != RESP) && (next_state == RESP);
   assign ram_we     = enter_resp && cur_write && !dec_err;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (req_valid) next_state = (WAIT_STATES > 0) ? WAIT : RESP;
         WAIT:    if (cnt == CNT_W'(1)) next_state = RESP;
         RESP:    if (rsp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rsp_err   <= 1'b0;
         load_ok_q <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            cnt     <= CNT_LOAD;
         end else if (state == WAIT) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (enter_resp) begin
            rsp_err   <= dec_err;
            load_ok_q <= !cur_write && !dec_err;
         end else if ((state == RESP) && rsp_ready) begin
            rsp_err   <= 1'b0;
            load_ok_q <= 1'b0;
         end
      end
   end

   dmem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (ram_we),
      .wstrb (cur_wstrb),
      .idx   (word[IDX_W-1:0]),
      .wdata (cur_wdata),
      .rdata (ram_rdata)
   );

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign rsp_rdata = load_ok_q ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) against a word-array reference model.
// Stimulus pushes expected responses; a negedge monitor pops and compares them.
module tb_dmem_responder;

   localparam int          DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h0000_2000;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      time         acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_write [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_wstrb [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   exp_t        q0[$];
   exp_t        q1[$];
   exp_t        cur [2];
   bit          in_rsp [2];
   logic [31:0] model [2][DEPTH];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(2)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_err(rsp_err[0])
   );

   dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_err(rsp_err[1])
   );

   function automatic int ws_of(int d);
      return (d == 0) ? 2 : 0;
   endfunction

   function automatic int qsize(int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour: byte offset from the base, word aligned and inside DEPTH words.
   function automatic bit ref_err(logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE;
      return (off % 4 != 0) || (off / 4 >= DEPTH);
   endfunction

   task automatic issue(int d, bit wr, logic [31:0] addr, logic [31:0] wdata,
                        logic [3:0] strb, bit track);
      int   n;
      int   idx;
      bit   err;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!req_ready[d] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready[d]) check("req_ready_wait", req_ready[d], 1);
      req_valid[d] = 1'b1;
      req_write[d] = wr;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_wstrb[d] = strb;
      @(posedge clk);
      if (track) begin
         err   = ref_err(addr);
         idx   = int'((addr - BASE) / 4);
         e.err = err;
         e.acc = $time;
         e.rdata = (!wr && !err) ? model[d][idx] : 32'h0;
         if (wr && !err) begin
            for (int b = 0; b < 4; b++)
               if (strb[b]) model[d][idx][8*b +: 8] = wdata[8*b +: 8];
         end
         if (d == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
   endtask

   task automatic wait_done(int d);
      int n;
      n = 0;
      @(negedge clk);
      req_valid[d] = 1'b0;
      while ((qsize(d) != 0 || rsp_valid[d] || !req_ready[d]) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("rsp_timeout", qsize(d), 0);
   endtask

   task automatic txn(int d, bit wr, logic [31:0] addr, logic [31:0] wdata, logic [3:0] strb);
      issue(d, wr, addr, wdata, strb, 1'b1);
      wait_done(d);
   endtask

   task automatic wait_rsp_valid(int d);
      int n;
      n = 0;
      while (!rsp_valid[d] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!rsp_valid[d]) check("rsp_valid_wait", rsp_valid[d], 1);
   endtask

   task automatic mon(int d);
      int lat;
      if (rst) begin
         in_rsp[d] = 1'b0;
      end else if (rsp_valid[d]) begin
         if (!in_rsp[d]) begin
            if (qsize(d) == 0) begin
               check("unexpected_rsp", qsize(d), 1);
            end else begin
               cur[d] = (d == 0) ? q0.pop_front() : q1.pop_front();
               lat = int'(($time - 5 - cur[d].acc) / 10) + 1;
               check($sformatf("latency_d%0d", d), lat, ws_of(d) + 1);
               check($sformatf("rsp_err_d%0d", d), rsp_err[d], cur[d].err);
               check($sformatf("rsp_rdata_d%0d", d), rsp_rdata[d], cur[d].rdata);
            end
            in_rsp[d] = 1'b1;
         end else begin
            check($sformatf("hold_err_d%0d", d), rsp_err[d], cur[d].err);
            check($sformatf("hold_rdata_d%0d", d), rsp_rdata[d], cur[d].rdata);
            check($sformatf("hold_ready_d%0d", d), req_ready[d], 0);
         end
      end else begin
         in_rsp[d] = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] addr;
      int          d;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0;
         req_wdata[i] = '0;   req_wstrb[i] = '0;  rsp_ready[i] = 1'b1;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("reset_req_ready", req_ready[i], 1);
         check("reset_rsp_valid", rsp_valid[i], 0);
         check("reset_rsp_err", rsp_err[i], 0);
      end

      // Give every word a known value in both instances.
      for (int i = 0; i < DEPTH; i++)
         for (int k = 0; k < 2; k++) txn(k, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF);

      for (int k = 0; k < 2; k++) begin
         txn(k, 1'b1, 32'h2004, 32'hDEAD_BEEF, 4'hF);
         txn(k, 1'b0, 32'h2004, 32'h0, 4'h0);
         txn(k, 1'b1, 32'h2008, 32'h1122_3344, 4'hF);
         txn(k, 1'b1, 32'h2008, 32'hAABB_CCDD, 4'h5);
         check("partial_strobe_model", model[k][2], 32'h11BB_33DD);
         txn(k, 1'b0, 32'h2008, 32'h0, 4'h0);
         txn(k, 1'b1, 32'h2008, 32'h5555_5555, 4'h0);
         txn(k, 1'b0, 32'h2008, 32'h0, 4'h0);
         txn(k, 1'b0, 32'h2002, 32'h0, 4'h0);
         txn(k, 1'b1, BASE + 32'(4 * DEPTH), 32'h9999_9999, 4'hF);
         txn(k, 1'b0, 32'h2000, 32'h0, 4'h0);
         txn(k, 1'b0, 32'h1FFC, 32'h0, 4'h0);
      end

      // Backpressure with a second request held on the bus.
      rsp_ready[0] = 1'b0;
      issue(0, 1'b0, 32'h2004, 32'h0, 4'h0, 1'b1);
      @(negedge clk);
      req_write[0] = 1'b1; req_addr[0] = 32'h2010; req_wdata[0] = 32'h5A5A_5A5A; req_wstrb[0] = 4'hF;
      wait_rsp_valid(0);
      repeat (5) @(negedge clk);
      req_valid[0] = 1'b0;
      rsp_ready[0] = 1'b1;
      wait_done(0);
      txn(0, 1'b0, 32'h2010, 32'h0, 4'h0);

      // Reset during WAIT abandons the store.
      txn(0, 1'b1, 32'h200C, 32'h1234_5678, 4'hF);
      issue(0, 1'b1, 32'h200C, 32'hCAFE_F00D, 4'hF, 1'b0);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("midop_rst_req_ready", req_ready[0], 1);
      check("midop_rst_rsp_valid", rsp_valid[0], 0);
      req_valid[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      txn(0, 1'b0, 32'h200C, 32'h0, 4'h0);

      // Reset during an error response clears the outputs immediately.
      rsp_ready[0] = 1'b0;
      issue(0, 1'b0, 32'h2002, 32'h0, 4'h0, 1'b1);
      @(negedge clk);
      req_valid[0] = 1'b0;
      wait_rsp_valid(0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_req_ready", req_ready[0], 1);
      check("async_rst_rsp_valid", rsp_valid[0], 0);
      check("async_rst_rsp_err", rsp_err[0], 0);
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      txn(1, 1'b1, 32'h200C, 32'hCAFE_F00D, 4'hF);
      txn(1, 1'b0, 32'h200C, 32'h0, 4'h0);

      for (int n = 0; n < 160; n++) begin
         d = n % 2;
         case ($urandom_range(0, 7))
            6:       addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            7:       addr = ($urandom % 2 == 0) ? BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000))
                                                : BASE - 32'(4 * $urandom_range(1, 1000));
            default: addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
         endcase
         txn(d, 1'($urandom % 2), addr, $urandom, 4'($urandom));
      end

      repeat (4) @(negedge clk);
      check("queues_drained", q0.size() + q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Responder (target) side of the core's data-memory interface: accepts load/store requests from the initiator over a valid/ready handshake and returns read data or a write acknowledgement. It models a word-addressed data RAM mapped at a base address, with configurable wait states, so multi-cycle cores and benches can exercise stall logic. It sits between the core's load/store path and the data storage array.

Parameters:
ADDR_WIDTH, 32, request address width in bits
DATA_WIDTH, 32, data word width in bits; must be 32 (byte strobes are 4 bits)
DEPTH, 64, number of data words stored
BASE_ADDR, 32'h00002000, byte address of word 0
WAIT_STATES, 2, extra cycles between request accept and response (0 allowed)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  initiator presents a request
req_ready  out  1  responder can accept a request this cycle
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data
req_wstrb  in  4  byte enables for stores; bit i covers byte i (little-endian)
rsp_valid  out  1  response available
rsp_ready  in  1  initiator accepts the response
rsp_rdata  out  DATA_WIDTH  load data; 0 for stores and errors
rsp_err  out  1  request was misaligned or out of range

Behaviour:
- Reset (async, while rst=1): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Storage contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. A request is accepted on a rising edge with req_valid=1. The responder latches write, addr, wdata and wstrb, and loads the counter with WAIT_STATES. Next state is WAIT if WAIT_STATES>0, else RESP.
- WAIT: req_ready=0. The counter decrements each cycle. When the counter reaches 1 on an edge, next state is RESP.
- RESP: rsp_valid=1, req_ready=0. The response stays stable until rsp_ready=1 on an edge, then next state is IDLE.
- Latency: rsp_valid rises exactly WAIT_STATES+1 cycles after the accepting edge. With rsp_ready held high, throughput is one request per WAIT_STATES+2 cycles.
- No back-to-back accept in the RESP-exit cycle; req_ready returns high only in IDLE.
- Address decode:
  - offset = req_addr - BASE_ADDR, modulo 2^ADDR_WIDTH.
  - index = offset[ADDR_WIDTH-1:2].
  - Error if offset[1:0] != 0 (misaligned) or index >= DEPTH. This covers addresses below BASE_ADDR through wrap-around.
- Store: the array is written once, on the edge that enters RESP, and only for bytes with wstrb=1. wstrb=0 is legal: no bytes change, rsp_err=0. On error, nothing is written.
- Load: rsp_rdata is registered from the array on the edge entering RESP. On error, rsp_rdata=0.
- rsp_err and rsp_rdata are held constant throughout RESP.
- Request inputs are ignored outside IDLE. A held req_valid is not accepted twice: it is accepted again only on a later IDLE edge.
- rst asserted in WAIT or RESP: the transaction is abandoned, and a pending store is not performed. A store already committed on entry to RESP remains in the array.

Decomposition:
- Package dmem_pkg holds:
  - the state enum typedef (IDLE/WAIT/RESP)
  - the default BASE_ADDR constant
  - the strobe width constant (4)
- Sub-module dmem_array: synchronous-write byte-strobed RAM, DEPTH x 32. Ports are clk, we, wstrb[3:0], idx, wdata, and a registered read-data output. It has no reset.
- dmem_responder holds the FSM, counter, decode and response registers.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge -> req_ready=1, rsp_valid=0, rsp_err=0 immediately.
- Store then load, WAIT_STATES=2:
  - Store addr 0x2004, wdata 0xDEADBEEF, wstrb 0xF -> rsp_valid exactly 3 cycles after accept, rsp_err=0.
  - Load 0x2004 -> rsp_rdata=0xDEADBEEF.
- Partial strobe: store 0x11223344 to 0x2008 with wstrb 0xF, then store 0xAABBCCDD with wstrb 0x5 -> load 0x2008 returns 0x11BB33DD.
- Errors:
  - Load 0x2002 -> rsp_err=1, rsp_rdata=0.
  - Store 0x2000+4*DEPTH -> rsp_err=1; prior contents of 0x2000 unchanged.
  - Load 0x1FFC -> rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0. A second req_valid during this window is not accepted.
- Reset mid-operation: accept a store of 0xCAFEF00D to 0x200C, assert rst during WAIT -> FSM back in IDLE, and a later load of 0x200C does not return 0xCAFEF00D. Repeat with WAIT_STATES=0 -> rsp_valid 1 cycle after accept.
